// File: rtl/lc3_mon_pkg.sv
// Shared types and constants for the LC-3 run monitor.
// Pure declarations: no latency and no flow control.
package lc3_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    BREAK = 2'b10,
    STOP  = 2'b11
  } mon_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    HALT    = 2'b01,
    BP      = 2'b10,
    TIMEOUT = 2'b11
  } stop_reason_t;

  localparam logic [15:0] HALT_OPCODE = 16'hF025;

endpackage

// File: rtl/lc3_bp_match.sv
// PC breakpoint comparator array; the lowest enabled matching slot wins.
// Purely combinational (zero latency); there is no backpressure.
module lc3_bp_match #(
  parameter int NUM_BP = 2,
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     hit,
  output logic [2:0]               index
);

  // Scan from the top down so that the lowest matching slot is written last.
  always_comb begin
    hit   = 1'b0;
    index = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W])) begin
        hit   = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/lc3_run_monitor.sv
// Run control and watchdog for the LC-3 core: gates cpu_en; stops on HALT, breakpoint or timeout.
// Stop takes effect on the edge after the cause (cpu_en drops with done); no backpressure.
module lc3_run_monitor
  import lc3_mon_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 50000,
  parameter int NUM_BP     = 2,
  parameter int ADDR_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     resume,
  input  logic                     fetch_done,
  input  logic [15:0]              ir,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     cpu_en,
  output logic                     running,
  output logic                     done,
  output logic [1:0]               stop_reason,
  output logic [2:0]               bp_index,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instr_count
);

  // Compare in 64 bits so a narrow counter never aliases onto a large limit.
  localparam bit          TO_EN  = (MAX_CYCLES != 0);
  localparam logic [63:0] TO_LIM = 64'(MAX_CYCLES) - 64'd1;

  mon_state_t   state, state_nxt;
  stop_reason_t reason_q;
  logic         bp_mask;
  logic         bp_hit;
  logic [2:0]   bp_idx;
  logic         fire_halt, fire_bp, fire_to;

  lc3_bp_match #(
    .NUM_BP (NUM_BP),
    .ADDR_W (ADDR_W)
  ) u_bp_match (
    .pc      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .hit     (bp_hit),
    .index   (bp_idx)
  );

  assign fire_halt = fetch_done && (ir == HALT_OPCODE);
  assign fire_bp   = fetch_done && bp_hit && !bp_mask;
  assign fire_to   = TO_EN && (64'(cycle_count) == TO_LIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (start)          state_nxt = RUN;
        else if (fire_halt) state_nxt = STOP;
        else if (fire_bp)   state_nxt = BREAK;
        else if (fire_to)   state_nxt = STOP;
      end
      BREAK: if (start || resume) state_nxt = RUN;
      STOP:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_en      = (state == RUN);
    running     = (state == RUN);
    stop_reason = reason_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done        <= 1'b0;
      reason_q    <= NONE;
      bp_index    <= 3'd0;
      bp_mask     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      done <= (state == RUN) && ((state_nxt == STOP) || (state_nxt == BREAK));
      if (start) begin
        reason_q    <= NONE;
        bp_index    <= 3'd0;
        bp_mask     <= 1'b0;
        cycle_count <= '0;
        instr_count <= '0;
      end else begin
        case (state)
          RUN: begin
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            if (fetch_done) begin
              bp_mask <= 1'b0;
              if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
            end
            if (fire_halt) begin
              reason_q <= HALT;
            end else if (fire_bp) begin
              reason_q <= BP;
              bp_index <= bp_idx;
            end else if (fire_to) begin
              reason_q <= TIMEOUT;
            end
          end
          // The core may still present the breakpoint's fetch after resume; mask it once.
          BREAK: begin
            if (resume) begin
              reason_q <= NONE;
              bp_mask  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lc3_run_monitor.sv
// Self-checking bench for lc3_run_monitor: vector table, directed corner cases, random vs model.
module tb_lc3_run_monitor;

  localparam int M_IDLE = 0, M_RUN = 1, M_BRK = 2, M_STOP = 3;

  logic        clock = 1'b0;
  logic        reset, start, resume, fetch_done;
  logic [15:0] ir, pc;
  logic [31:0] bp_addr;
  logic [1:0]  bp_en;

  logic        cpu_en [3];
  logic        running[3];
  logic        done   [3];
  logic [1:0]  rsn    [3];
  logic [2:0]  bpi    [3];
  logic [31:0] cyc_a, ins_a, cyc_b, ins_b;
  logic [3:0]  cyc_c, ins_c;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  lc3_run_monitor #(.CNT_W(32), .MAX_CYCLES(100), .NUM_BP(2), .ADDR_W(16)) u0 (
    .clock(clock), .reset(reset), .start(start), .resume(resume), .fetch_done(fetch_done),
    .ir(ir), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .cpu_en(cpu_en[0]), .running(running[0]),
    .done(done[0]), .stop_reason(rsn[0]), .bp_index(bpi[0]), .cycle_count(cyc_a), .instr_count(ins_a));

  lc3_run_monitor #(.CNT_W(32), .MAX_CYCLES(0), .NUM_BP(2), .ADDR_W(16)) u1 (
    .clock(clock), .reset(reset), .start(start), .resume(resume), .fetch_done(fetch_done),
    .ir(ir), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .cpu_en(cpu_en[1]), .running(running[1]),
    .done(done[1]), .stop_reason(rsn[1]), .bp_index(bpi[1]), .cycle_count(cyc_b), .instr_count(ins_b));

  lc3_run_monitor #(.CNT_W(4), .MAX_CYCLES(50000), .NUM_BP(2), .ADDR_W(16)) u2 (
    .clock(clock), .reset(reset), .start(start), .resume(resume), .fetch_done(fetch_done),
    .ir(ir), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .cpu_en(cpu_en[2]), .running(running[2]),
    .done(done[2]), .stop_reason(rsn[2]), .bp_index(bpi[2]), .cycle_count(cyc_c), .instr_count(ins_c));

  // Reference model: one record per instance, advanced once per clock edge.
  typedef struct {
    int     mode;
    longint cyc;
    longint ins;
    int     reason;
    int     idx;
    bit     mask;
    bit     done;
  } mdl_t;

  mdl_t   m  [3];
  longint lim[3];
  longint top[3];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = M_IDLE; r.cyc = 0; r.ins = 0; r.reason = 0; r.idx = 0; r.mask = 0; r.done = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t s, longint lim_k, longint top_k);
    mdl_t n;
    int   hit;
    bit   halt;
    n      = s;
    n.done = 0;
    hit    = -1;
    if (start) begin
      n.mode = M_RUN; n.cyc = 0; n.ins = 0; n.reason = 0; n.idx = 0; n.mask = 0;
      return n;
    end
    if (s.mode == M_RUN) begin
      halt = fetch_done && (ir == 16'hF025);
      for (int i = 0; i < 2; i++)
        if (hit < 0 && fetch_done && !s.mask && bp_en[i] && pc == bp_addr[i*16 +: 16]) hit = i;
      n.cyc = (s.cyc < top_k) ? s.cyc + 1 : top_k;
      if (fetch_done) begin
        n.ins  = (s.ins < top_k) ? s.ins + 1 : top_k;
        n.mask = 0;
      end
      if (halt) begin
        n.mode = M_STOP; n.reason = 1; n.done = 1;
      end else if (hit >= 0) begin
        n.mode = M_BRK; n.reason = 2; n.idx = hit; n.done = 1;
      end else if (lim_k != 0 && s.cyc == lim_k - 1) begin
        n.mode = M_STOP; n.reason = 3; n.done = 1;
      end
    end else if (s.mode == M_BRK && resume) begin
      n.mode = M_RUN; n.reason = 0; n.mask = 1;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      logic [63:0] ac, ai;
      case (k)
        0:       begin ac = 64'(cyc_a); ai = 64'(ins_a); end
        1:       begin ac = 64'(cyc_b); ai = 64'(ins_b); end
        default: begin ac = 64'(cyc_c); ai = 64'(ins_c); end
      endcase
      chk($sformatf("u%0d cpu_en", k),      64'(cpu_en[k]),  64'(m[k].mode == M_RUN));
      chk($sformatf("u%0d running", k),     64'(running[k]), 64'(m[k].mode == M_RUN));
      chk($sformatf("u%0d done", k),        64'(done[k]),    64'(m[k].done));
      chk($sformatf("u%0d stop_reason", k), 64'(rsn[k]),     64'(m[k].reason));
      chk($sformatf("u%0d bp_index", k),    64'(bpi[k]),     64'(m[k].idx));
      chk($sformatf("u%0d cycle_count", k), ac,              64'(m[k].cyc));
      chk($sformatf("u%0d instr_count", k), ai,              64'(m[k].ins));
    end
  endtask

  // Inputs change only at the falling edge; the model steps on the rising edge.
  task automatic tick();
    @(posedge clock);
    for (int k = 0; k < 3; k++) m[k] = reset ? mdl_reset() : mdl_next(m[k], lim[k], top[k]);
    @(negedge clock);
    cmp_all();
  endtask

  task automatic drive(input bit st, input bit rs, input bit fd, input logic [15:0] i_ir, input logic [15:0] i_pc);
    start = st; resume = rs; fetch_done = fd; ir = i_ir; pc = i_pc;
  endtask

  typedef struct {
    bit          st, rs, fd;
    logic [15:0] ir, pc;
    bit          e_run, e_done;
    logic [1:0]  e_rsn;
    logic [2:0]  e_idx;
    int          e_cyc, e_ins;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(bit st, bit rs, bit fd, logic [15:0] vir, logic [15:0] vpc,
                             bit er, bit ed, logic [1:0] ersn, logic [2:0] eidx, int ec, int ei);
    vec_t r;
    r.st = st; r.rs = rs; r.fd = fd; r.ir = vir; r.pc = vpc;
    r.e_run = er; r.e_done = ed; r.e_rsn = ersn; r.e_idx = eidx; r.e_cyc = ec; r.e_ins = ei;
    return r;
  endfunction

  initial begin
    bit found;
    int ticks;

    lim[0] = 100; lim[1] = 0;     lim[2] = 50000;
    top[0] = 64'hFFFF_FFFF; top[1] = 64'hFFFF_FFFF; top[2] = 15;
    for (int k = 0; k < 3; k++) m[k] = mdl_reset();

    reset = 1'b1;
    drive(0, 0, 0, 16'h0000, 16'h3000);
    bp_addr = {16'h3004, 16'h3002};
    bp_en   = 2'b10;
    #2;
    chk("reset running", 64'(running[0]), 64'd0);
    chk("reset cpu_en",  64'(cpu_en[0]),  64'd0);
    chk("reset cycles",  64'(cyc_a),      64'd0);
    @(negedge clock);
    tick();
    reset = 1'b0;

    // Halt run, breakpoint/resume with mask, start beating resume, halt-over-breakpoint priority.
    tv.push_back(v(1,0,0,16'h0000,16'h3100, 1,0,2'd0,3'd0,0,0));
    tv.push_back(v(0,0,1,16'h1021,16'h3100, 1,0,2'd0,3'd0,1,1));
    tv.push_back(v(0,0,1,16'h1021,16'h3101, 1,0,2'd0,3'd0,2,2));
    tv.push_back(v(0,0,1,16'h1021,16'h3102, 1,0,2'd0,3'd0,3,3));
    tv.push_back(v(0,0,1,16'h1021,16'h3103, 1,0,2'd0,3'd0,4,4));
    tv.push_back(v(0,0,1,16'h1021,16'h3104, 1,0,2'd0,3'd0,5,5));
    tv.push_back(v(0,0,1,16'hF025,16'h3105, 0,1,2'd1,3'd0,6,6));
    tv.push_back(v(0,0,0,16'h0000,16'h3106, 0,0,2'd1,3'd0,6,6));
    tv.push_back(v(0,1,0,16'h0000,16'h3106, 0,0,2'd1,3'd0,6,6));
    tv.push_back(v(1,0,0,16'h0000,16'h3003, 1,0,2'd0,3'd0,0,0));
    tv.push_back(v(0,0,1,16'h1021,16'h3003, 1,0,2'd0,3'd0,1,1));
    tv.push_back(v(0,0,0,16'h1021,16'h3004, 1,0,2'd0,3'd0,2,1));
    tv.push_back(v(0,0,1,16'h1021,16'h3004, 0,1,2'd2,3'd1,3,2));
    tv.push_back(v(0,0,0,16'h1021,16'h3004, 0,0,2'd2,3'd1,3,2));
    tv.push_back(v(0,1,0,16'h1021,16'h3004, 1,0,2'd0,3'd1,3,2));
    tv.push_back(v(0,0,1,16'h1021,16'h3004, 1,0,2'd0,3'd1,4,3));
    tv.push_back(v(0,0,1,16'h1021,16'h3005, 1,0,2'd0,3'd1,5,4));
    tv.push_back(v(0,0,1,16'h1021,16'h3004, 0,1,2'd2,3'd1,6,5));
    tv.push_back(v(1,1,1,16'h1021,16'h3002, 1,0,2'd0,3'd0,0,0));
    tv.push_back(v(0,0,1,16'hF025,16'h3004, 0,1,2'd1,3'd0,1,1));
    tv.push_back(v(0,0,0,16'h0000,16'h3004, 0,0,2'd1,3'd0,1,1));

    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].rs, tv[i].fd, tv[i].ir, tv[i].pc);
      tick();
      chk($sformatf("vec%0d running", i),     64'(running[0]), 64'(tv[i].e_run));
      chk($sformatf("vec%0d cpu_en", i),      64'(cpu_en[0]),  64'(tv[i].e_run));
      chk($sformatf("vec%0d done", i),        64'(done[0]),    64'(tv[i].e_done));
      chk($sformatf("vec%0d stop_reason", i), 64'(rsn[0]),     64'(tv[i].e_rsn));
      chk($sformatf("vec%0d bp_index", i),    64'(bpi[0]),     64'(tv[i].e_idx));
      chk($sformatf("vec%0d cycle_count", i), 64'(cyc_a),      64'(tv[i].e_cyc));
      chk($sformatf("vec%0d instr_count", i), 64'(ins_a),      64'(tv[i].e_ins));
    end

    // Watchdog on u0 (limit 100); u1 has it disabled, u2 saturates its 4-bit counter.
    drive(1, 0, 0, 16'h0000, 16'h3100);
    tick();
    drive(0, 0, 0, 16'h0000, 16'h3100);
    ticks = 0;
    found = 0;
    while (ticks < 200 && !found) begin
      tick();
      ticks++;
      if (done[0]) found = 1;
    end
    chk("watchdog fired", 64'(found), 64'd1);
    chk("watchdog cycle_count", 64'(cyc_a), 64'd100);
    chk("watchdog stop_reason", 64'(rsn[0]), 64'd3);
    chk("watchdog cpu_en", 64'(cpu_en[0]), 64'd0);
    while (ticks < 1000) begin
      tick();
      ticks++;
    end
    chk("no-watchdog running", 64'(running[1]), 64'd1);
    chk("no-watchdog cycle_count", 64'(cyc_b), 64'd1000);
    chk("saturated cycle_count", 64'(cyc_c), 64'd15);
    chk("narrow counter no timeout", 64'(running[2]), 64'd1);

    // Asynchronous reset in the middle of a run.
    drive(1, 0, 0, 16'h0000, 16'h3100);
    tick();
    drive(0, 0, 0, 16'h0000, 16'h3100);
    for (int i = 0; i < 37; i++) tick();
    chk("pre-reset cycle_count", 64'(cyc_a), 64'd37);
    #2 reset = 1'b1;
    #1;
    chk("async reset running", 64'(running[0]), 64'd0);
    chk("async reset cpu_en",  64'(cpu_en[0]),  64'd0);
    chk("async reset cycles",  64'(cyc_a),      64'd0);
    chk("async reset done",    64'(done[0]),    64'd0);
    @(negedge clock);
    tick();
    chk("no done after reset", 64'(done[0]), 64'd0);
    reset = 1'b0;

    // Random traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      reset      = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 39) == 0);
      resume     = ($urandom_range(0, 5) == 0);
      fetch_done = ($urandom_range(0, 2) == 0);
      ir         = ($urandom_range(0, 39) == 0) ? 16'hF025 : 16'($urandom);
      pc         = 16'h3000 + 16'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) begin
        bp_addr = {16'h3000 + 16'($urandom_range(0, 5)), 16'h3000 + 16'($urandom_range(0, 5))};
        bp_en   = 2'($urandom_range(0, 3));
      end
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lc3_run_monitor.md
Name: lc3_run_monitor

Overview:
- Synthesizable run-control and watchdog block that sits beside the LC_3 core. It replaces the fixed-time stop in the top-level bench with stopping driven by the CPU itself.
- Gates the core through a clock-enable.
- Counts cycles and retired instructions.
- Stops on HALT (TRAP x25), on a PC breakpoint, or on a programmable cycle timeout.
- Benches and FPGA wrappers instantiate it the same way.

Parameters:
- CNT_W, 32, width of cycle and instruction counters.
- MAX_CYCLES, 50000, watchdog limit in clock cycles (1 ms at 20 ns); 0 disables the watchdog.
- NUM_BP, 2, number of PC breakpoint comparators (1..8).
- ADDR_W, 16, PC/breakpoint address width.

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse: clear counters and begin a run.
- resume, in, 1, one-cycle pulse: continue after a breakpoint stop.
- fetch_done, in, 1, pulse from core FSM when IR is loaded (one per instruction).
- ir, in, 16, current instruction register.
- pc, in, ADDR_W, current program counter.
- bp_addr, in, NUM_BP*ADDR_W, packed breakpoint addresses; slot i is at [i*ADDR_W +: ADDR_W].
- bp_en, in, NUM_BP, per-slot breakpoint enable.
- cpu_en, out, 1, clock-enable to the LC_3 core.
- running, out, 1, high in RUN state.
- done, out, 1, one-cycle pulse on entry to STOP or BREAK.
- stop_reason, out, 2, 00 none, 01 halt, 10 breakpoint, 11 timeout.
- bp_index, out, 3, slot number of the breakpoint that hit.
- cycle_count, out, CNT_W, cycles spent in RUN.
- instr_count, out, CNT_W, fetch_done pulses seen in RUN.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, cpu_en 0, running 0, done 0, stop_reason 00, bp_index 0, both counters 0.
- States: IDLE, RUN, BREAK, STOP.
- IDLE:
  - start -> RUN next edge; counters cleared on that edge; stop_reason 00.
  - resume ignored.
- RUN:
  - cpu_en = 1 (combinational from state).
  - cycle_count increments every cycle; instr_count increments on fetch_done.
  - Stop conditions are evaluated each cycle. Priority when simultaneous: halt > breakpoint > timeout.
- Halt condition: fetch_done && ir == 16'hF025 -> STOP, stop_reason 01. The HALT instruction is counted.
- Breakpoint condition: fetch_done && bp_en[i] && pc == slot i. The lowest hitting index wins -> BREAK, stop_reason 10, bp_index = i. The instruction is counted.
- Timeout condition: MAX_CYCLES != 0 and cycle_count == MAX_CYCLES-1 on this cycle -> STOP, stop_reason 11. cycle_count ends at MAX_CYCLES.
- done: one-cycle pulse on the edge that enters STOP or BREAK. cpu_en drops on that same edge, so the core executes no further cycle.
- BREAK:
  - cpu_en 0; counters hold.
  - resume -> RUN; stop_reason returns to 00.
  - The breakpoint at the same PC must not retrigger until the next fetch_done. A one-bit mask, cleared by the next fetch_done, enforces this.
  - start in BREAK -> RUN with counters cleared (start beats resume).
- STOP:
  - cpu_en 0; counters and stop_reason hold.
  - start -> new run. resume ignored.
- start while RUN: restart; counters cleared, remain in RUN.
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-run: everything returns to reset values immediately; no done pulse.

Decomposition:
- Package lc3_mon_pkg:
  - state enum: IDLE, RUN, BREAK, STOP.
  - stop_reason enum: NONE, HALT, BP, TIMEOUT.
  - localparam HALT_OPCODE = 16'hF025.
- Sub-module lc3_bp_match (parametrised NUM_BP/ADDR_W):
  - combinational comparator array with priority encoder.
  - outputs hit and index.

Test Plan:
- Halt: reset, start, drive 5 fetch_done with ir=x1021 then one with ir=xF025 -> STOP, stop_reason 01, instr_count 6, done pulses exactly once, cpu_en 0 on the same edge.
- Breakpoint and resume: bp_addr slot1 = x3004, bp_en = 2'b10, pc reaches x3004 on fetch_done -> BREAK, bp_index 1. Pulse resume -> RUN, no immediate re-hit. Next fetch at x3005 proceeds.
- Watchdog: MAX_CYCLES=100, no halt -> STOP at cycle_count 100, stop_reason 11. Repeat with MAX_CYCLES=0 for 1000 cycles -> still RUN.
- Priority: same cycle fetch_done, ir=xF025, pc matching enabled bp -> stop_reason 01, state STOP.
- Async reset: assert reset mid-cycle during RUN with cycle_count 37 -> outputs zero before the next edge, state IDLE, no done.
- Saturation: CNT_W=4, run 20 cycles -> cycle_count holds 15.
